// File: rtl/etx_arbiter_if.sv
// etx_arbiter_if: channel bundle between the emesh FIFO side and the
// transmit arbiter.
//   txrr_* / txwr_* / txrd_* : access + packet in, wait out (one per channel)
//   tx_wr_wait / tx_rd_wait  : remote pushback, already synchronized
//   tx_io_wait               : downstream IO busy
//   tx_access / tx_packet / tx_burst : registered output packet stream
// The slave modport is the arbiter's view; master is the driving side.
interface etx_arbiter_if #(
    parameter int PW = 104
);
    logic          txrr_access;
    logic [PW-1:0] txrr_packet;
    logic          txrr_wait;
    logic          txwr_access;
    logic [PW-1:0] txwr_packet;
    logic          txwr_wait;
    logic          txrd_access;
    logic [PW-1:0] txrd_packet;
    logic          txrd_wait;
    logic          tx_wr_wait;
    logic          tx_rd_wait;
    logic          tx_io_wait;
    logic          tx_access;
    logic [PW-1:0] tx_packet;
    logic          tx_burst;

    modport slave (
        input  txrr_access, txrr_packet, txwr_access, txwr_packet,
               txrd_access, txrd_packet, tx_wr_wait, tx_rd_wait, tx_io_wait,
        output txrr_wait, txwr_wait, txrd_wait, tx_access, tx_packet, tx_burst
    );

    modport master (
        output txrr_access, txrr_packet, txwr_access, txwr_packet,
               txrd_access, txrd_packet, tx_wr_wait, tx_rd_wait, tx_io_wait,
        input  txrr_wait, txwr_wait, txrd_wait, tx_access, tx_packet, tx_burst
    );
endinterface

// File: rtl/etx_arbiter.sv
// etx_arbiter: schedules the read-response, write and read-request emesh
// channels onto the single registered packet stream feeding the serializer.
//   clk    : core clock (tx_lclk_div4)
//   nreset : asynchronous active-low reset
//   bus    : etx_arbiter_if.slave (channel requests/waits, pushback, output)
// Priority: an open write burst continues first, then read responses, then
// read requests / writes in round-robin. Write continuation beats
// (datamode 11, same ctrlmode, address +8) are flagged on tx_burst.
module etx_arbiter #(
    parameter int PW       = 104,
    parameter int AW       = 32,
    parameter int BURSTMAX = 16
) (
    input  logic         clk,
    input  logic         nreset,
    etx_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURSTMAX);

    typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

    state_t        state_q, state_d;
    logic          tx_access_q, tx_access_d;
    logic          tx_burst_q, tx_burst_d;
    logic [PW-1:0] tx_packet_q, tx_packet_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          ptr_wr_q, ptr_wr_d;   // 1: wr has round-robin priority

    logic slot_free, rr_ok, wr_ok, rd_ok, wr_chain;
    logic grant_rr, grant_wr, grant_rd;

    assign slot_free = ~tx_access_q | ~bus.tx_io_wait;
    assign rr_ok     = bus.txrr_access & ~bus.tx_wr_wait;
    assign wr_ok     = bus.txwr_access & ~bus.tx_wr_wait;
    assign rd_ok     = bus.txrd_access & ~bus.tx_rd_wait;

    // BURST implies the held packet is a wr-channel grant with datamode 11,
    // so only the candidate side and the beat limit need checking here.
    assign wr_chain = (state_q == BURST)
                    && (burst_cnt_q < CW'(BURSTMAX - 1))
                    && wr_ok
                    && bus.txwr_packet[0]
                    && (bus.txwr_packet[2:1] == 2'b11)
                    && (bus.txwr_packet[6:3] == tx_packet_q[6:3])
                    && (bus.txwr_packet[AW+7:8] == tx_packet_q[AW+7:8] + AW'(8));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            tx_access_q <= 1'b0;
            tx_burst_q  <= 1'b0;
            tx_packet_q <= '0;
            burst_cnt_q <= '0;
            ptr_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_access_q <= tx_access_d;
            tx_burst_q  <= tx_burst_d;
            tx_packet_q <= tx_packet_d;
            burst_cnt_q <= burst_cnt_d;
            ptr_wr_q    <= ptr_wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_access_d = tx_access_q;
        tx_burst_d  = tx_burst_q;
        tx_packet_d = tx_packet_q;
        burst_cnt_d = burst_cnt_q;
        ptr_wr_d    = ptr_wr_q;
        if (grant_rr | grant_wr | grant_rd) begin
            tx_access_d = 1'b1;
            if (grant_rr)      tx_packet_d = bus.txrr_packet;
            else if (grant_wr) tx_packet_d = bus.txwr_packet;
            else               tx_packet_d = bus.txrd_packet;
            if (grant_wr && wr_chain) begin
                state_d     = BURST;
                burst_cnt_d = burst_cnt_q + 1'b1;
                tx_burst_d  = 1'b1;
            end else if (grant_wr && (bus.txwr_packet[2:1] == 2'b11)) begin
                state_d     = BURST;
                burst_cnt_d = '0;
                tx_burst_d  = 1'b0;
            end else begin
                state_d     = SINGLE;
                burst_cnt_d = '0;
                tx_burst_d  = 1'b0;
            end
            if (grant_wr)      ptr_wr_d = 1'b0;
            else if (grant_rd) ptr_wr_d = 1'b1;
        end else if (slot_free) begin
            state_d     = IDLE;
            tx_access_d = 1'b0;
            tx_burst_d  = 1'b0;
            burst_cnt_d = '0;
        end
    end

    always_comb begin
        grant_rr = 1'b0;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (slot_free) begin
            if (wr_chain)                       grant_wr = 1'b1;
            else if (rr_ok)                     grant_rr = 1'b1;
            else if (rd_ok && (!ptr_wr_q || !wr_ok)) grant_rd = 1'b1;
            else if (wr_ok)                     grant_wr = 1'b1;
        end
        bus.txrr_wait = bus.txrr_access & ~grant_rr;
        bus.txwr_wait = bus.txwr_access & ~grant_wr;
        bus.txrd_wait = bus.txrd_access & ~grant_rd;
        bus.tx_access = tx_access_q;
        bus.tx_packet = tx_packet_q;
        bus.tx_burst  = tx_burst_q;
    end
endmodule

// File: tb/tb_etx_arbiter.sv
module tb_etx_arbiter;
    localparam int PW = 104;
    localparam int AW = 32;
    localparam int BM = 4;
    localparam int G_NONE = 0;
    localparam int G_RR   = 1;
    localparam int G_WR   = 2;
    localparam int G_RD   = 3;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    etx_arbiter_if #(.PW(PW)) bus ();
    etx_arbiter #(.PW(PW), .AW(AW), .BURSTMAX(BM)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkp(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkpkt(input logic [7:0] tag, input logic wr,
                                            input logic [1:0] dm, input logic [3:0] cm,
                                            input logic [31:0] addr);
        logic [PW-1:0] p;
        p = '0;
        p[0]          = wr;
        p[2:1]        = dm;
        p[6:3]        = cm;
        p[AW+7:8]     = addr;
        p[PW-1 -: 8]  = tag;
        return p;
    endfunction

    // ---------------- reference model ----------------
    logic          m_acc = 1'b0;
    logic          m_burst = 1'b0;
    logic          m_from_wr = 1'b0;
    logic          m_rd_turn = 1'b1;
    logic [PW-1:0] m_pkt = '0;
    int            m_beats = 0;       // beats in the current write run
    int            m_g = G_NONE;
    logic          m_chain = 1'b0;
    logic          m_slot = 1'b0;
    logic [PW-1:0] m_cand = '0;

    function automatic logic follows(input logic [PW-1:0] held, input logic [PW-1:0] c);
        logic [31:0] ha, ca;
        ha = held[AW+7:8];
        ca = c[AW+7:8];
        return c[0] && (c[2:1] == 2'b11) && (c[6:3] == held[6:3]) && (ca == ha + 32'd8);
    endfunction

    always @(negedge clk) begin
        if (nreset) begin
            logic slot, rr_ok, wr_ok, rd_ok, lock, chain;
            int g;
            slot  = !m_acc || !bus.tx_io_wait;
            rr_ok = bus.txrr_access && !bus.tx_wr_wait;
            wr_ok = bus.txwr_access && !bus.tx_wr_wait;
            rd_ok = bus.txrd_access && !bus.tx_rd_wait;
            lock  = m_acc && m_from_wr && (m_pkt[2:1] == 2'b11) && (m_beats < BM);
            g = G_NONE;
            chain = 1'b0;
            if (slot) begin
                if (lock && wr_ok && follows(m_pkt, bus.txwr_packet)) begin
                    g = G_WR;
                    chain = 1'b1;
                end else if (rr_ok) g = G_RR;
                else if (rd_ok && (m_rd_turn || !wr_ok)) g = G_RD;
                else if (wr_ok) g = G_WR;
            end
            check1("txrr_wait", bus.txrr_wait, bus.txrr_access && (g != G_RR));
            check1("txwr_wait", bus.txwr_wait, bus.txwr_access && (g != G_WR));
            check1("txrd_wait", bus.txrd_wait, bus.txrd_access && (g != G_RD));
            check1("tx_access", bus.tx_access, m_acc);
            if (m_acc) begin
                checkp("tx_packet", bus.tx_packet, m_pkt);
                check1("tx_burst", bus.tx_burst, m_burst);
            end
            m_g     <= g;
            m_chain <= chain;
            m_slot  <= slot;
            m_cand  <= (g == G_RR) ? bus.txrr_packet :
                       (g == G_WR) ? bus.txwr_packet : bus.txrd_packet;
        end else begin
            m_g <= G_NONE;
        end
    end

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_acc     <= 1'b0;
            m_burst   <= 1'b0;
            m_from_wr <= 1'b0;
            m_rd_turn <= 1'b1;
            m_beats   <= 0;
        end else if (m_g != G_NONE) begin
            m_acc     <= 1'b1;
            m_pkt     <= m_cand;
            m_from_wr <= (m_g == G_WR);
            if (m_chain) begin
                m_beats <= m_beats + 1;
                m_burst <= 1'b1;
            end else begin
                m_burst <= 1'b0;
                m_beats <= (m_g == G_WR && m_cand[2:1] == 2'b11) ? 1 : 0;
            end
            if (m_g == G_RD)      m_rd_turn <= 1'b0;
            else if (m_g == G_WR) m_rd_turn <= 1'b1;
        end else if (m_slot) begin
            m_acc   <= 1'b0;
            m_burst <= 1'b0;
            m_beats <= 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.txrr_access = 1'b0;
        bus.txwr_access = 1'b0;
        bus.txrd_access = 1'b0;
        bus.tx_wr_wait  = 1'b0;
        bus.tx_rd_wait  = 1'b0;
        bus.tx_io_wait  = 1'b0;
    endtask

    // Presents n write packets back to back and returns the tx_burst bit
    // seen for each of them (bit i = packet i).
    task automatic wr_seq(input logic [PW-1:0] pk [8], input int n, output logic [7:0] bursts);
        bursts = '0;
        for (int i = 0; i <= n; i++) begin
            tick();
            if (i < n) begin
                bus.txwr_access = 1'b1;
                bus.txwr_packet = pk[i];
            end else begin
                bus.txwr_access = 1'b0;
            end
            @(negedge clk);
            if (i > 0) bursts[i-1] = bus.tx_burst;
        end
        tick();
    endtask

    task automatic dw_run(input logic [31:0] base, input logic [31:0] step, input int n,
                          output logic [PW-1:0] pk [8]);
        for (int i = 0; i < 8; i++)
            pk[i] = mkpkt(8'(16 + i), 1'b1, 2'b11, 4'd0, base + step * i);
        if (n < 0) pk[0] = '0;
    endtask

    logic [PW-1:0] seq [8];
    logic [7:0]    bv;
    logic [7:0]    gv;
    logic [PW-1:0] p1, pw, pk210;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        bus.txrr_packet = '0;
        bus.txwr_packet = '0;
        bus.txrd_packet = '0;
        @(negedge clk);
        check1("reset_tx_access", bus.tx_access, 1'b0);
        check1("reset_tx_burst", bus.tx_burst, 1'b0);
        checkp("reset_tx_packet", bus.tx_packet, '0);
        tick();
        nreset = 1'b1;

        // single read request
        p1 = mkpkt(8'd1, 1'b0, 2'b10, 4'd0, 32'h8000_0000);
        tick();
        bus.txrd_access = 1'b1;
        bus.txrd_packet = p1;
        @(negedge clk);
        check1("rd_wait_first", bus.txrd_wait, 1'b0);
        tick();
        bus.txrd_access = 1'b0;
        @(negedge clk);
        check1("rd_out_access", bus.tx_access, 1'b1);
        checkp("rd_out_packet", bus.tx_packet, p1);
        check1("rd_out_burst", bus.tx_burst, 1'b0);
        tick();
        @(negedge clk);
        check1("rd_out_gone", bus.tx_access, 1'b0);

        // 4-beat burst
        dw_run(32'h100, 32'd8, 4, seq);
        wr_seq(seq, 4, bv);
        check8("burst4", bv, 8'b0000_1110);
        // address gap breaks the burst
        dw_run(32'h100, 32'h10, 2, seq);
        wr_seq(seq, 2, bv);
        check8("burst_gap", bv, 8'b0000_0000);
        // six beats against BURSTMAX=4
        dw_run(32'h0, 32'd8, 6, seq);
        wr_seq(seq, 6, bv);
        check8("burst_max", bv, 8'b0010_1110);
        // address wrap continues the burst
        dw_run(32'hFFFF_FFF8, 32'd8, 2, seq);
        wr_seq(seq, 2, bv);
        check8("burst_wrap", bv, 8'b0000_0010);
        // ctrlmode change breaks the burst
        dw_run(32'h300, 32'd8, 2, seq);
        seq[1][6:3] = 4'd1;
        wr_seq(seq, 2, bv);
        check8("burst_ctrl", bv, 8'b0000_0000);

        // rd/wr round-robin from reset
        tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        bus.txrd_access = 1'b1;
        bus.txrd_packet = mkpkt(8'd3, 1'b0, 2'b10, 4'd0, 32'h4000);
        bus.txwr_access = 1'b1;
        bus.txwr_packet = mkpkt(8'd4, 1'b1, 2'b01, 4'd0, 32'h5000);
        gv = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gv[2*i +: 2] = !bus.txrd_wait ? 2'd1 : (!bus.txwr_wait ? 2'd2 : 2'd0);
            tick();
        end
        check8("rr_alternate", gv, 8'h99);
        bus.tx_rd_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("rdpush_rd_wait", bus.txrd_wait, 1'b1);
            check1("rdpush_wr_go", bus.txwr_wait, 1'b0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // write pushback blocks rr and wr, rd passes; rr then beats wr
        bus.txrr_access = 1'b1;
        bus.txrr_packet = mkpkt(8'd5, 1'b0, 2'b10, 4'd0, 32'h6000);
        bus.txwr_access = 1'b1;
        bus.txrd_access = 1'b1;
        bus.tx_wr_wait  = 1'b1;
        @(negedge clk);
        check1("wrpush_rd_go", bus.txrd_wait, 1'b0);
        check1("wrpush_rr_wait", bus.txrr_wait, 1'b1);
        check1("wrpush_wr_wait", bus.txwr_wait, 1'b1);
        tick();
        bus.tx_wr_wait = 1'b0;
        @(negedge clk);
        check1("rr_first_go", bus.txrr_wait, 1'b0);
        check1("rr_first_wr", bus.txwr_wait, 1'b1);
        check1("rr_first_rd", bus.txrd_wait, 1'b1);
        tick();
        idle_inputs();
        tick();
        tick();

        // downstream hold
        pw = mkpkt(8'd7, 1'b1, 2'b01, 4'd2, 32'h7000);
        bus.txwr_access = 1'b1;
        bus.txwr_packet = pw;
        tick();
        bus.tx_io_wait  = 1'b1;
        bus.txrr_access = 1'b1;
        bus.txrd_access = 1'b1;
        bus.txwr_packet = mkpkt(8'd8, 1'b1, 2'b01, 4'd2, 32'h7100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("hold_access", bus.tx_access, 1'b1);
            checkp("hold_packet", bus.tx_packet, pw);
            check1("hold_rr_wait", bus.txrr_wait, 1'b1);
            check1("hold_wr_wait", bus.txwr_wait, 1'b1);
            check1("hold_rd_wait", bus.txrd_wait, 1'b1);
            tick();
        end
        bus.tx_io_wait = 1'b0;
        @(negedge clk);
        check1("release_rr_go", bus.txrr_wait, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();

        // reset in the middle of a burst
        bus.txwr_access = 1'b1;
        bus.txwr_packet = mkpkt(8'd9, 1'b1, 2'b11, 4'd0, 32'h200);
        tick();
        bus.txwr_packet = mkpkt(8'd10, 1'b1, 2'b11, 4'd0, 32'h208);
        tick();
        bus.txwr_access = 1'b0;
        @(negedge clk);
        check1("midburst_burst", bus.tx_burst, 1'b1);
        #2;
        nreset = 1'b0;
        #1;
        check1("rst_async_access", bus.tx_access, 1'b0);
        check1("rst_async_burst", bus.tx_burst, 1'b0);
        tick();
        nreset = 1'b1;
        pk210 = mkpkt(8'd11, 1'b1, 2'b11, 4'd0, 32'h210);
        bus.txwr_access = 1'b1;
        bus.txwr_packet = pk210;
        tick();
        bus.txwr_access = 1'b0;
        @(negedge clk);
        check1("post_rst_access", bus.tx_access, 1'b1);
        checkp("post_rst_packet", bus.tx_packet, pk210);
        check1("post_rst_burst", bus.tx_burst, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
